// File: rtl/keypad_scan_fifo.sv
// keypad_scan_fifo
//   Scans a ROWS x COLS switch matrix by driving one column at a time,
//   debounces presses and releases, and queues key codes (row*COLS+col)
//   into a first-word-fall-through FIFO. Optional auto-repeat while held.
//
// Ports
//   clock      single rising-edge clock
//   reset      asynchronous active-low reset
//   row        raw keypad rows (1 = key connects driven column to row)
//   col        one-hot column drive
//   read       pop request (ignored when empty)
//   clear_ovf  synchronous clear of the sticky overflow flag
//   data_out   FIFO head code (0 while empty)
//   valid      !empty
//   empty/full FIFO status
//   overflow   sticky: a push was dropped because the FIFO was full
//   count      current occupancy
module keypad_scan_fifo #(
   parameter int ROWS     = 4,
   parameter int COLS     = 4,
   parameter int CODE_W   = 4,
   parameter int DEPTH    = 8,
   parameter int DEBOUNCE = 4,
   parameter int REPEAT   = 0
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [ROWS-1:0]          row,
   output logic [COLS-1:0]          col,
   input  logic                     read,
   input  logic                     clear_ovf,
   output logic [CODE_W-1:0]        data_out,
   output logic                     valid,
   output logic                     empty,
   output logic                     full,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam int RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE - 1);
   localparam logic [RW-1:0] REP_LAST = RW'((REPEAT > 0) ? REPEAT - 1 : 0);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_HELD, ST_RELEASE} state_t;

   state_t              state, state_n;
   logic [ROWS-1:0]     rs_meta, rs, cap_rs;
   logic [CW-1:0]       col_idx, col_next;
   logic [1:0]          dwell;
   logic [DW-1:0]       deb_cnt;
   logic [RW-1:0]       rep_cnt;
   logic [CODE_W-1:0]   code_c, cap_code;
   logic                scan_hit, deb_same, push;

   // two-flop synchronizer; everything downstream uses rs only
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rs_meta <= '0;
         rs      <= '0;
      end else begin
         rs_meta <= row;
         rs      <= rs_meta;
      end
   end

   // lowest set row wins when several rows are active
   always_comb begin
      code_c = '0;
      for (int i = ROWS - 1; i >= 0; i--)
         if (rs[i]) code_c = CODE_W'(i * COLS + int'(col_idx));
   end

   assign col_next = (col_idx == COL_LAST) ? '0 : col_idx + 1'b1;
   assign scan_hit = (dwell == 2'd3) && (rs != '0);
   // cap_rs is never zero, so equality also implies rs != 0
   assign deb_same = (rs == cap_rs);

   // ---- FSM: state register ----
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= ST_SCAN;
      else        state <= state_n;
   end

   // ---- FSM: next state ----
   always_comb begin
      state_n = state;
      case (state)
         ST_SCAN:     if (scan_hit) state_n = ST_DEBOUNCE;
         ST_DEBOUNCE: if (!deb_same) state_n = ST_SCAN;
                      else if (deb_cnt == DEB_LAST) state_n = ST_HELD;
         ST_HELD:     if (rs == '0) state_n = ST_RELEASE;
         ST_RELEASE:  if (rs != '0) state_n = ST_HELD;
                      else if (deb_cnt == DEB_LAST) state_n = ST_SCAN;
         default:     state_n = ST_SCAN;
      endcase
   end

   // ---- FSM: outputs ----
   always_comb begin
      col          = '0;
      col[col_idx] = 1'b1;
      push         = 1'b0;
      case (state)
         ST_DEBOUNCE: push = deb_same && (deb_cnt == DEB_LAST);
         ST_HELD:     push = (REPEAT > 0) && (rs != '0) && (rep_cnt == REP_LAST);
         default:     push = 1'b0;
      endcase
   end

   // scan / debounce / repeat counters; column stays frozen outside SCAN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         col_idx  <= '0;
         dwell    <= '0;
         deb_cnt  <= '0;
         rep_cnt  <= '0;
         cap_rs   <= '0;
         cap_code <= '0;
      end else begin
         case (state)
            ST_SCAN: begin
               if (dwell == 2'd3) begin
                  dwell <= '0;
                  if (rs != '0) begin
                     cap_rs   <= rs;
                     cap_code <= code_c;
                     deb_cnt  <= '0;
                  end else begin
                     col_idx <= col_next;
                  end
               end else begin
                  dwell <= dwell + 2'd1;
               end
            end
            ST_DEBOUNCE: begin
               if (!deb_same) begin
                  col_idx <= col_next;
                  dwell   <= '0;
               end else if (deb_cnt == DEB_LAST) begin
                  rep_cnt <= '0;
               end else begin
                  deb_cnt <= deb_cnt + 1'b1;
               end
            end
            ST_HELD: begin
               if (rs == '0)
                  deb_cnt <= '0;
               else if (REPEAT > 0)
                  rep_cnt <= (rep_cnt == REP_LAST) ? '0 : rep_cnt + 1'b1;
            end
            ST_RELEASE: begin
               if (rs != '0) begin
                  rep_cnt <= '0;
               end else if (deb_cnt == DEB_LAST) begin
                  col_idx <= col_next;
                  dwell   <= '0;
                  deb_cnt <= '0;
               end else begin
                  deb_cnt <= deb_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // ---- FIFO ----
   logic [CODE_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wptr, rptr;
   logic              do_pop, do_push;

   assign empty    = (count == '0);
   assign full     = (count == FULL_CNT);
   assign valid    = !empty;
   assign do_pop   = read && !empty;
   // a pop on the same edge frees the slot, so full+pop still accepts
   assign do_push  = push && (!full || do_pop);
   assign data_out = empty ? '0 : mem[rptr];

   always_ff @(posedge clock) begin
      if (do_push) mem[wptr] <= cap_code;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // a drop on the same edge as clear_ovf wins
         if (push && !do_push) overflow <= 1'b1;
         else if (clear_ovf)   overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_keypad_scan_fifo.sv
module tb_keypad_scan_fifo;

   localparam int D   = 4;
   localparam int LAT = 4 * 4 + D + 3;

   logic       clock, reset;
   logic [3:0] row0, col0, data_out0, count0;
   logic       read0, clr0, valid0, empty0, full0, ovf0;
   logic [3:0] row1, col1, data_out1, count1;
   logic       read1, valid1, empty1, full1, ovf1;

   logic       k0_on, pulse0, k1_on;
   logic [1:0] k0_r, k0_c;

   int n_chk = 0;
   int n_fail = 0;
   int q0[$];
   int q1[$];

   keypad_scan_fifo u0 (
      .clock(clock), .reset(reset), .row(row0), .col(col0), .read(read0),
      .clear_ovf(clr0), .data_out(data_out0), .valid(valid0), .empty(empty0),
      .full(full0), .overflow(ovf0), .count(count0));

   keypad_scan_fifo #(.REPEAT(20)) u1 (
      .clock(clock), .reset(reset), .row(row1), .col(col1), .read(read1),
      .clear_ovf(1'b0), .data_out(data_out1), .valid(valid1), .empty(empty1),
      .full(full1), .overflow(ovf1), .count(count1));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // keypad switch models: a pressed key shorts its column to its row
   always_comb begin
      row0 = '0;
      if (pulse0) row0 = '1;
      else if (k0_on && col0[k0_c]) row0[k0_r] = 1'b1;
   end

   always_comb begin
      row1 = '0;
      if (k1_on && col1[3]) row1[3] = 1'b1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_chk++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, want);
      end
   endtask

   // scoreboard monitors: compare the head whenever a pop is presented
   always @(negedge clock) begin
      if (reset && read0 && valid0) begin
         if (q0.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL pop0_unexpected: got %0d expected none", data_out0);
         end else chk("pop0_data", data_out0, q0.pop_front());
      end
      if (reset && read1 && valid1) begin
         if (q1.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL pop1_unexpected: got %0d expected none", data_out1);
         end else chk("pop1_data", data_out1, q1.pop_front());
      end
   end

   task automatic tick();
      @(posedge clock); #1;
   endtask

   task automatic rd0();
      read0 = 1'b1; tick(); read0 = 1'b0;
   endtask

   // press key k, optionally verify first-entry latency and fall-through,
   // hold for `hold` more clocks, release and let the scanner settle
   task automatic press0(input int k, input int hold, input bit lat_chk);
      int  c0;
      bit  got;
      c0 = count0; got = 1'b0;
      k0_r = 2'(k / 4); k0_c = 2'(k % 4); k0_on = 1'b1;
      for (int i = 0; i < LAT && !got; i++) begin
         tick();
         if (count0 != 4'(c0)) got = 1'b1;
      end
      if (lat_chk) begin
         chk("press_latency", got, 1);
         if (c0 == 0) begin
            chk("fwft_valid", valid0, 1);
            chk("fwft_data", data_out0, k);
         end
      end
      repeat (hold) tick();
      k0_on = 1'b0;
      repeat (30) tick();
   endtask

   // press key k and drive read/clear_ovf on exactly the push edge: the
   // column holds 4 clocks in scan, then D more in debounce before the push
   task automatic press_sync0(input int k, input bit rd, input bit clr);
      logic [3:0] prev;
      int         st;
      bit         done;
      k0_r = 2'(k / 4); k0_c = 2'(k % 4); k0_on = 1'b1;
      prev = col0; st = 0; done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         tick();
         if (col0 !== prev) begin prev = col0; st = 0; end
         else st++;
         if (st == 3 + D) begin
            read0 = rd; clr0 = clr;
            tick();
            read0 = 1'b0; clr0 = 1'b0;
            done = 1'b1;
         end
      end
      chk("sync_push_found", done, 1);
      repeat (40) tick();
      k0_on = 1'b0;
      repeat (30) tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] prev;
      int         st;
      bit         got;
      reset = 1'b0; read0 = 1'b0; clr0 = 1'b0; read1 = 1'b0;
      k0_on = 1'b0; pulse0 = 1'b0; k1_on = 1'b0; k0_r = '0; k0_c = '0;
      #2;
      chk("rst_col", col0, 4'b0001);
      chk("rst_count", count0, 0);
      chk("rst_empty", empty0, 1);
      chk("rst_full", full0, 0);
      chk("rst_valid", valid0, 0);
      chk("rst_ovf", ovf0, 0);
      chk("rst_data", data_out0, 0);
      chk("rst_u1_count", count1, 0);
      repeat (3) tick();
      reset = 1'b1;
      repeat (4) tick();

      // single long press of key 6
      q0.push_back(6);
      press0(6, 100, 1'b1);
      chk("k6_count", count0, 1);
      chk("k6_valid", valid0, 1);
      chk("k6_data", data_out0, 6);
      rd0();
      chk("k6_empty", empty0, 1);
      chk("k6_count0", count0, 0);

      // read while empty is ignored
      rd0();
      chk("rd_empty_count", count0, 0);
      chk("rd_empty_flag", empty0, 1);

      // short glitches at various scan phases never push
      for (int p = 0; p < 6; p++) begin
         repeat (p + 1) tick();
         pulse0 = 1'b1; tick(); tick(); pulse0 = 1'b0;
         repeat (30) tick();
      end
      chk("glitch_count", count0, 0);

      // fill to full, then one dropped push
      for (int k = 0; k < 9; k++) begin
         if (k < 8) q0.push_back(k);
         press0(k, 40, k < 8);
         if (k == 7) chk("fill_full", full0, 1);
      end
      chk("ovf_set", ovf0, 1);
      chk("ovf_count", count0, 8);
      chk("ovf_full", full0, 1);
      for (int i = 0; i < 8; i++) rd0();
      chk("drain_empty", empty0, 1);
      clr0 = 1'b1; tick(); clr0 = 1'b0;
      chk("ovf_cleared", ovf0, 0);

      // refill: 9..15 then 0
      for (int k = 9; k < 17; k++) begin
         q0.push_back(k % 16);
         press0(k % 16, 40, 1'b1);
      end
      chk("refill_count", count0, 8);

      // clear_ovf on the same edge as a dropped push keeps overflow set
      press_sync0(1, 1'b0, 1'b1);
      chk("clr_vs_drop_ovf", ovf0, 1);
      chk("clr_vs_drop_count", count0, 8);
      clr0 = 1'b1; tick(); clr0 = 1'b0;
      chk("ovf_cleared2", ovf0, 0);

      // push and pop together while full
      q0.push_back(2);
      press_sync0(2, 1'b1, 1'b0);
      chk("full_pp_count", count0, 8);
      chk("full_pp_ovf", ovf0, 0);
      chk("full_pp_full", full0, 1);
      for (int i = 0; i < 8; i++) rd0();
      chk("final_drain_empty", empty0, 1);
      chk("sb0_all_popped", q0.size(), 0);

      // reset asserted while a press is being debounced
      k0_r = 2'd1; k0_c = 2'd1; k0_on = 1'b1;
      prev = col0; st = 0; got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         tick();
         if (col0 !== prev) begin prev = col0; st = 0; end
         else st++;
         if (st == 5) got = 1'b1;
      end
      chk("mid_deb_found", got, 1);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_col", col0, 4'b0001);
      chk("mid_rst_count", count0, 0);
      chk("mid_rst_empty", empty0, 1);
      chk("mid_rst_valid", valid0, 0);
      chk("mid_rst_ovf", ovf0, 0);
      chk("mid_rst_data", data_out0, 0);
      k0_on = 1'b0;
      tick(); tick();
      reset = 1'b1;
      repeat (40) tick();
      chk("post_rst_count", count0, 0);
      chk("post_rst_empty", empty0, 1);

      // auto-repeat: key F, held state lasts about 65 clocks
      k1_on = 1'b1; got = 1'b0;
      for (int i = 0; i < LAT && !got; i++) begin
         tick();
         if (count1 != 4'd0) got = 1'b1;
      end
      chk("rep_first_push", got, 1);
      repeat (63) tick();
      k1_on = 1'b0;
      repeat (40) tick();
      chk("rep_count", count1, 4);
      for (int i = 0; i < 4; i++) q1.push_back(15);
      for (int i = 0; i < 4; i++) begin
         read1 = 1'b1; tick(); read1 = 1'b0;
      end
      chk("rep_empty", empty1, 1);
      chk("sb1_all_popped", q1.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
